// File: rtl/drlp_pkg.sv
// Shared definitions for the DRLP layer sequencer: state encoding,
// configuration word layout, decoded configuration record and read-target
// constants.
package drlp_pkg;

   localparam int DRLP_BASE_SHIFT = 11;
   localparam int CFG_WORDS       = 4;

   localparam logic RD_SEL_IMG = 1'b0;
   localparam logic RD_SEL_WGT = 1'b1;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_WGT_REQ  = 3'd1;
   localparam state_t ST_WGT_WAIT = 3'd2;
   localparam state_t ST_IMG_REQ  = 3'd3;
   localparam state_t ST_IMG_WAIT = 3'd4;
   localparam state_t ST_COMPUTE  = 3'd5;
   localparam state_t ST_WRITE    = 3'd6;
   localparam state_t ST_DONE     = 3'd7;

   localparam logic [1:0] CFG_W_STATIC = 2'd0;
   localparam logic [1:0] CFG_W_YZ     = 2'd1;
   localparam logic [1:0] CFG_W_BASE   = 2'd2;
   localparam logic [1:0] CFG_W_WRCNT  = 2'd3;

   // word 0
   localparam int MODE_LSB   = 14;
   localparam int POOL_LSB   = 12;
   localparam int RELU_BIT   = 11;
   localparam int STRIDE_LSB = 8;
   localparam int PSUM_LSB   = 4;
   // word 1
   localparam int ZMOVE_LSB  = 9;
   localparam int YMOVE_LSB  = 2;
   // word 2
   localparam int IMGB_LSB   = 11;
   localparam int WGTB_LSB   = 6;
   localparam int XMOVE_LSB  = 0;

   typedef struct packed {
      logic [1:0]  mode;
      logic [1:0]  pool;
      logic        relu;
      logic [2:0]  stride;
      logic [3:0]  psum_shift;
      logic [6:0]  zmove;
      logic [6:0]  ymove;
      logic [4:0]  img_base;
      logic [4:0]  wgt_base;
      logic [5:0]  xmove;
      logic [15:0] img_wr_count;
   } cfg_t;

   // Last loop index for a move count; a count of 0 behaves as 1.
   function automatic logic [6:0] last_idx(input logic [6:0] cnt);
      return (cnt == 7'd0) ? 7'd0 : 7'(cnt - 7'd1);
   endfunction

endpackage

// File: rtl/drlp_cfg_regs.sv
// Four-word configuration register file with field decode.
//   clk_sys, rst  : clock, synchronous active-high reset
//   wr_allow      : writes accepted only while the sequencer is idle
//   wr_en/addr/wdata : host write port
//   cfg           : decoded configuration fields
module drlp_cfg_regs
   import drlp_pkg::*;
(
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        wr_allow,
   input  logic        wr_en,
   input  logic [1:0]  addr,
   input  logic [15:0] wdata,
   output cfg_t        cfg
);

   logic [15:0] cfg_word [CFG_WORDS];
   logic        unused_rsvd;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         for (int i = 0; i < CFG_WORDS; i++) cfg_word[i] <= '0;
      end else if (wr_en && wr_allow) begin
         cfg_word[addr] <= wdata;
      end
   end

   always_comb begin
      cfg              = '0;
      cfg.mode         = cfg_word[CFG_W_STATIC][MODE_LSB +: 2];
      cfg.pool         = cfg_word[CFG_W_STATIC][POOL_LSB +: 2];
      cfg.relu         = cfg_word[CFG_W_STATIC][RELU_BIT];
      cfg.stride       = cfg_word[CFG_W_STATIC][STRIDE_LSB +: 3];
      cfg.psum_shift   = cfg_word[CFG_W_STATIC][PSUM_LSB +: 4];
      cfg.zmove        = cfg_word[CFG_W_YZ][ZMOVE_LSB +: 7];
      cfg.ymove        = cfg_word[CFG_W_YZ][YMOVE_LSB +: 7];
      cfg.img_base     = cfg_word[CFG_W_BASE][IMGB_LSB +: 5];
      cfg.wgt_base     = cfg_word[CFG_W_BASE][WGTB_LSB +: 5];
      cfg.xmove        = cfg_word[CFG_W_BASE][XMOVE_LSB +: 6];
      cfg.img_wr_count = cfg_word[CFG_W_WRCNT];
   end

   // reserved bits are held in the registers but drive nothing
   assign unused_rsvd = ^{cfg_word[CFG_W_STATIC][3:0], cfg_word[CFG_W_YZ][1:0]};

endmodule

// File: rtl/drlp_layer_sequencer.sv
// DRLP layer sequencer: holds the layer configuration, broadcasts the static
// datapath fields and walks the z/y/x tile loops (weight read, image read,
// PE compute, result write), pulsing o_finish when the layer is complete.
//   i_cfg*        : host configuration write port (idle only)
//   i_start       : layer start pulse (idle only)
//   o_dma_rd_*    : read request / ready / done handshake
//   o_pe_start    : compute launch, i_pe_done completion
//   o_dma_wr_*    : result write request, held until i_dma_wr_done
//   o_x/y/z_idx   : current tile indices
//
// state    | meaning
// IDLE     | waiting for start, config writable
// WGT_REQ  | weight read request for plane z
// WGT_WAIT | weight transfer in flight
// IMG_REQ  | image read request for tile (y,x)
// IMG_WAIT | image transfer in flight
// COMPUTE  | PE array running
// WRITE    | result write, advances indices on completion
// DONE     | layer complete, finish pulse follows
module drlp_layer_sequencer
   import drlp_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int BASE_SHIFT = DRLP_BASE_SHIFT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [15:0]       i_cfg,
   input  logic [1:0]        i_cfg_addr,
   input  logic              i_cfg_wr_en,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_finish,
   output logic [1:0]        o_mode,
   output logic [1:0]        o_pool,
   output logic              o_relu,
   output logic [2:0]        o_stride,
   output logic [3:0]        o_psum_shift,
   output logic              o_dma_rd_req,
   output logic              o_dma_rd_sel,
   output logic [ADDR_W-1:0] o_dma_rd_addr,
   input  logic              i_dma_rd_ready,
   input  logic              i_dma_rd_done,
   output logic              o_pe_start,
   input  logic              i_pe_done,
   output logic              o_dma_wr_req,
   output logic [ADDR_W-1:0] o_dma_wr_addr,
   output logic [15:0]       o_dma_wr_len,
   input  logic              i_dma_wr_done,
   output logic [5:0]        o_x_idx,
   output logic [6:0]        o_y_idx,
   output logic [6:0]        o_z_idx
);

   state_t            state;
   cfg_t              cfg;
   logic [5:0]        x_idx;
   logic [6:0]        y_idx;
   logic [6:0]        z_idx;
   logic [ADDR_W-1:0] wr_ptr;

   logic [5:0]        xmove_eff;
   logic [5:0]        x_last;
   logic [6:0]        y_last;
   logic [6:0]        z_last;
   logic [12:0]       yx_prod;
   logic [ADDR_W-1:0] wgt_addr;
   logic [ADDR_W-1:0] img_addr;

   drlp_cfg_regs u_cfg_regs (
      .clk_sys  (i_clk),
      .rst      (i_rst),
      .wr_allow (state == ST_IDLE),
      .wr_en    (i_cfg_wr_en),
      .addr     (i_cfg_addr),
      .wdata    (i_cfg),
      .cfg      (cfg)
   );

   assign xmove_eff = (cfg.xmove == 6'd0) ? 6'd1 : cfg.xmove;
   assign x_last    = 6'(last_idx({1'b0, cfg.xmove}));
   assign y_last    = last_idx(cfg.ymove);
   assign z_last    = last_idx(cfg.zmove);

   // addresses wrap at ADDR_W bits; the tile offset product is 13 bits wide
   assign yx_prod  = 13'(y_idx) * 13'(xmove_eff);
   assign wgt_addr = (ADDR_W'(cfg.wgt_base) << BASE_SHIFT) + ADDR_W'(z_idx);
   assign img_addr = (ADDR_W'(cfg.img_base) << BASE_SHIFT) + ADDR_W'(yx_prod)
                     + ADDR_W'(x_idx);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= ST_IDLE;
         x_idx         <= '0;
         y_idx         <= '0;
         z_idx         <= '0;
         wr_ptr        <= '0;
         o_dma_rd_req  <= 1'b0;
         o_dma_rd_sel  <= 1'b0;
         o_dma_rd_addr <= '0;
         o_pe_start    <= 1'b0;
         o_finish      <= 1'b0;
      end else begin
         o_pe_start <= 1'b0;
         o_finish   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state  <= ST_WGT_REQ;
                  x_idx  <= '0;
                  y_idx  <= '0;
                  z_idx  <= '0;
                  wr_ptr <= '0;
               end
            end
            ST_WGT_REQ: begin
               if (o_dma_rd_req && i_dma_rd_ready) begin
                  o_dma_rd_req <= 1'b0;
                  state        <= ST_WGT_WAIT;
               end else if (!o_dma_rd_req) begin
                  o_dma_rd_req  <= 1'b1;
                  o_dma_rd_sel  <= RD_SEL_WGT;
                  o_dma_rd_addr <= wgt_addr;
               end
            end
            ST_WGT_WAIT: begin
               if (i_dma_rd_done) state <= ST_IMG_REQ;
            end
            ST_IMG_REQ: begin
               if (o_dma_rd_req && i_dma_rd_ready) begin
                  o_dma_rd_req <= 1'b0;
                  state        <= ST_IMG_WAIT;
               end else if (!o_dma_rd_req) begin
                  o_dma_rd_req  <= 1'b1;
                  o_dma_rd_sel  <= RD_SEL_IMG;
                  o_dma_rd_addr <= img_addr;
               end
            end
            ST_IMG_WAIT: begin
               if (i_dma_rd_done) begin
                  state      <= ST_COMPUTE;
                  o_pe_start <= 1'b1;
               end
            end
            ST_COMPUTE: begin
               if (i_pe_done) state <= ST_WRITE;
            end
            ST_WRITE: begin
               if (i_dma_wr_done) begin
                  wr_ptr <= wr_ptr + ADDR_W'(cfg.img_wr_count);
                  state  <= ST_IMG_REQ;
                  if (x_idx == x_last) begin
                     x_idx <= '0;
                     if (y_idx == y_last) begin
                        y_idx <= '0;
                        if (z_idx == z_last) begin
                           z_idx <= '0;
                           state <= ST_DONE;
                        end else begin
                           z_idx <= z_idx + 7'd1;
                           state <= ST_WGT_REQ;
                        end
                     end else begin
                        y_idx <= y_idx + 7'd1;
                     end
                  end else begin
                     x_idx <= x_idx + 6'd1;
                  end
               end
            end
            ST_DONE: begin
               o_finish <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy        = (state != ST_IDLE);
   assign o_dma_wr_req  = (state == ST_WRITE);
   assign o_dma_wr_addr = wr_ptr;
   assign o_dma_wr_len  = cfg.img_wr_count;
   assign o_mode        = cfg.mode;
   assign o_pool        = cfg.pool;
   assign o_relu        = cfg.relu;
   assign o_stride      = cfg.stride;
   assign o_psum_shift  = cfg.psum_shift;
   assign o_x_idx       = x_idx;
   assign o_y_idx       = y_idx;
   assign o_z_idx       = z_idx;

endmodule

// File: tb/tb_drlp_layer_sequencer.sv
module tb_drlp_layer_sequencer;

   logic        clk = 1'b0;
   logic        i_rst, i_cfg_wr_en, i_start;
   logic [15:0] i_cfg;
   logic [1:0]  i_cfg_addr;
   logic        o_busy, o_finish, o_relu;
   logic [1:0]  o_mode, o_pool;
   logic [2:0]  o_stride;
   logic [3:0]  o_psum_shift;
   logic        o_dma_rd_req, o_dma_rd_sel, i_dma_rd_ready, i_dma_rd_done;
   logic [15:0] o_dma_rd_addr, o_dma_wr_addr, o_dma_wr_len;
   logic        o_pe_start, i_pe_done, o_dma_wr_req, i_dma_wr_done;
   logic [5:0]  o_x_idx;
   logic [6:0]  o_y_idx, o_z_idx;

   always #5 clk = ~clk;

   drlp_layer_sequencer #(.ADDR_W(16), .BASE_SHIFT(11)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_cfg(i_cfg), .i_cfg_addr(i_cfg_addr),
      .i_cfg_wr_en(i_cfg_wr_en), .i_start(i_start), .o_busy(o_busy),
      .o_finish(o_finish), .o_mode(o_mode), .o_pool(o_pool), .o_relu(o_relu),
      .o_stride(o_stride), .o_psum_shift(o_psum_shift),
      .o_dma_rd_req(o_dma_rd_req), .o_dma_rd_sel(o_dma_rd_sel),
      .o_dma_rd_addr(o_dma_rd_addr), .i_dma_rd_ready(i_dma_rd_ready),
      .i_dma_rd_done(i_dma_rd_done), .o_pe_start(o_pe_start),
      .i_pe_done(i_pe_done), .o_dma_wr_req(o_dma_wr_req),
      .o_dma_wr_addr(o_dma_wr_addr), .o_dma_wr_len(o_dma_wr_len),
      .i_dma_wr_done(i_dma_wr_done), .o_x_idx(o_x_idx), .o_y_idx(o_y_idx),
      .o_z_idx(o_z_idx)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- DMA / PE responder ----------------
   int lat   = 3;
   bit stall = 1'b0;
   int ncnt = 0, fin_cnt = 0, fin_n = 0, wrdone_n = 0, pe_cnt = 0;
   int rd_phase = 0, rd_cnt = 0, pe_phase = 0, pe_wait = 0, wr_phase = 0, wr_cnt = 0;
   logic [16:0] rd_log[$];
   logic [15:0] wr_addr_log[$];
   logic [15:0] wr_len_log[$];

   initial begin
      i_dma_rd_ready = 0; i_dma_rd_done = 0; i_pe_done = 0; i_dma_wr_done = 0;
      forever begin
         @(negedge clk);
         ncnt++;
         i_dma_rd_ready = 0; i_dma_rd_done = 0; i_pe_done = 0; i_dma_wr_done = 0;
         if (o_finish) begin fin_cnt++; fin_n = ncnt; end
         if (rd_phase == 0 && o_dma_rd_req) begin
            rd_log.push_back({o_dma_rd_sel, o_dma_rd_addr});
            rd_cnt = lat; rd_phase = 1;
         end else if (rd_phase == 2) begin
            if (rd_cnt == 0) begin i_dma_rd_done = 1; rd_phase = 0; end
            else rd_cnt--;
         end
         if (rd_phase == 1 && !stall) begin
            if (rd_cnt == 0) begin i_dma_rd_ready = 1; rd_phase = 2; rd_cnt = lat; end
            else rd_cnt--;
         end
         if (o_pe_start) begin pe_cnt++; pe_wait = lat; pe_phase = 1; end
         if (pe_phase == 1) begin
            if (pe_wait == 0) begin i_pe_done = 1; pe_phase = 0; end
            else pe_wait--;
         end
         if (wr_phase == 0 && o_dma_wr_req) begin
            wr_addr_log.push_back(o_dma_wr_addr);
            wr_len_log.push_back(o_dma_wr_len);
            wr_cnt = lat; wr_phase = 1;
         end
         if (wr_phase == 1) begin
            if (wr_cnt == 0) begin i_dma_wr_done = 1; wr_phase = 0; wrdone_n = ncnt; end
            else wr_cnt--;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int rd_base, wr_base, pe_base, fin_base;

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      i_cfg_addr = a; i_cfg = d; i_cfg_wr_en = 1;
      @(negedge clk);
      i_cfg_wr_en = 0;
   endtask

   task automatic start_layer();
      rd_base = rd_log.size(); wr_base = wr_addr_log.size();
      pe_base = pe_cnt; fin_base = fin_cnt;
      i_start = 1;
      @(negedge clk);
      i_start = 0;
   endtask

   task automatic wait_finish(input string tag, input int budget);
      for (int i = 0; i < budget && fin_cnt == fin_base; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check_eq({tag, " finish count"}, fin_cnt - fin_base, 1);
      check_eq({tag, " finish latency"}, fin_n - wrdone_n, 2);
      check_eq({tag, " busy after finish"}, o_busy, 0);
   endtask

   // zmove=2, ymove=1, xmove=3 pattern: W(z) then I(x) x3, for z=0,1
   task automatic check_reads_2x3(input string tag, input int wgt, input int img);
      int k;
      check_eq({tag, " read count"}, rd_log.size() - rd_base, 8);
      k = rd_base;
      for (int z = 0; z < 2; z++) begin
         if (k < rd_log.size())
            check_eq($sformatf("%s wgt read z%0d", tag, z), rd_log[k], {1'b1, 16'(wgt + z)});
         k++;
         for (int x = 0; x < 3; x++) begin
            if (k < rd_log.size())
               check_eq($sformatf("%s img read z%0d x%0d", tag, z, x), rd_log[k], {1'b0, 16'(img + x)});
            k++;
         end
      end
   endtask

   task automatic check_writes(input string tag, input int n, input int len);
      check_eq({tag, " write count"}, wr_addr_log.size() - wr_base, n);
      check_eq({tag, " pe_start count"}, pe_cnt - pe_base, n);
      for (int i = 0; i < n; i++) begin
         if (wr_base + i < wr_addr_log.size()) begin
            check_eq($sformatf("%s wr addr %0d", tag, i), wr_addr_log[wr_base + i], 16'(i * len));
            check_eq($sformatf("%s wr len %0d", tag, i), wr_len_log[wr_base + i], len);
         end
      end
   endtask

   function automatic logic [15:0] img_model(input int base, input int xm, input int n);
      int y = n / xm;
      int x = n % xm;
      return 16'((base << 11) + y * xm + x);
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      bit found;
      i_rst = 1; i_cfg = 0; i_cfg_addr = 0; i_cfg_wr_en = 0; i_start = 0;
      repeat (3) @(negedge clk);
      i_rst = 0;
      @(negedge clk);
      check_eq("reset busy", o_busy, 0);
      check_eq("reset reqs", {o_dma_rd_req, o_dma_wr_req, o_pe_start, o_finish}, 0);
      check_eq("reset cfg outs", {o_mode, o_pool, o_relu, o_stride, o_psum_shift, o_dma_wr_len}, 0);
      check_eq("reset addrs", {o_dma_rd_addr, o_dma_wr_addr}, 0);
      check_eq("reset idx", {o_x_idx, o_y_idx, o_z_idx}, 0);

      // 1: full layer run
      cfg_write(2'd0, 16'hCE00);
      cfg_write(2'd1, 16'h0404);
      cfg_write(2'd2, 16'h0003);
      cfg_write(2'd3, 16'd200);
      check_eq("t1 mode", o_mode, 3);
      check_eq("t1 relu", o_relu, 1);
      check_eq("t1 stride", o_stride, 6);
      check_eq("t1 pool/psum", {o_pool, o_psum_shift}, 0);
      start_layer();
      check_eq("t1 busy", o_busy, 1);
      wait_finish("t1", 2000);
      check_reads_2x3("t1", 0, 0);
      check_writes("t1", 6, 200);

      // 3: config write and second start during the run
      start_layer();
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (o_pe_start) found = 1;
      end
      check_eq("t3 reached compute", found, 1);
      i_start = 1; i_cfg_addr = 2'd3; i_cfg = 16'd5; i_cfg_wr_en = 1;
      @(negedge clk);
      i_start = 0; i_cfg_wr_en = 0;
      wait_finish("t3", 2000);
      check_eq("t3 wr_len kept", o_dma_wr_len, 200);
      check_writes("t3", 6, 200);
      repeat (20) @(negedge clk);
      check_eq("t3 no second run", fin_cnt - fin_base, 1);
      check_eq("t3 idle", o_busy, 0);

      // 4: read ready stall, with non-zero bases
      cfg_write(2'd2, 16'h1143);           // img_base=2, wgt_base=5, xmove=3
      stall = 1;
      start_layer();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (o_dma_rd_req) found = 1; else @(negedge clk);
      end
      check_eq("t4 req seen", found, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq($sformatf("t4 stall req %0d", i), o_dma_rd_req, 1);
         check_eq($sformatf("t4 stall addr %0d", i), {o_dma_rd_sel, o_dma_rd_addr}, {1'b1, 16'h2800});
      end
      check_eq("t4 no pe during stall", pe_cnt - pe_base, 0);
      stall = 0;
      wait_finish("t4", 2000);
      check_reads_2x3("t4", 16'h2800, 16'h1000);
      check_writes("t4", 6, 200);

      // 5: reset while in IMG_WAIT
      start_layer();
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (o_dma_rd_req && o_dma_rd_sel == 1'b0) found = 1;
      end
      for (int i = 0; i < 20 && found && o_dma_rd_req; i++) @(negedge clk);
      check_eq("t5 reached img_wait", found && !o_dma_rd_req && o_busy, 1);
      i_rst = 1;
      @(negedge clk);
      i_rst = 0;
      check_eq("t5 busy", o_busy, 0);
      check_eq("t5 reqs", {o_dma_rd_req, o_dma_wr_req, o_pe_start}, 0);
      check_eq("t5 cfg outs", {o_mode, o_pool, o_relu, o_stride, o_psum_shift, o_dma_wr_len}, 0);
      repeat (8) @(negedge clk);

      // 2: zero counts (registers cleared by the reset above)
      start_layer();
      wait_finish("t2", 500);
      check_eq("t2 read count", rd_log.size() - rd_base, 2);
      if (rd_log.size() - rd_base >= 2) begin
         check_eq("t2 wgt read", rd_log[rd_base], {1'b1, 16'h0000});
         check_eq("t2 img read", rd_log[rd_base + 1], {1'b0, 16'h0000});
      end
      check_writes("t2", 1, 0);

      // 6: image address wrap, fast responder
      lat = 0;
      cfg_write(2'd1, 16'h03FC);           // zmove=1, ymove=127
      cfg_write(2'd2, 16'hF83F);           // img_base=31, wgt_base=0, xmove=63
      cfg_write(2'd3, 16'd1);
      start_layer();
      for (int i = 0; i < 20000 && (rd_log.size() - rd_base) < 2101; i++) @(negedge clk);
      i_rst = 1;
      @(negedge clk);
      i_rst = 0;
      check_eq("t6 read count", (rd_log.size() - rd_base) >= 2101, 1);
      if (rd_log.size() - rd_base >= 2101) begin
         check_eq("t6 wgt read", rd_log[rd_base], {1'b1, 16'h0000});
         for (int n = 0; n < 2100; n++)
            check_eq($sformatf("t6 img read %0d", n), rd_log[rd_base + 1 + n], {1'b0, img_model(31, 63, n)});
         check_eq("t6 last before wrap", rd_log[rd_base + 2048], {1'b0, 16'hFFFF});
         check_eq("t6 first after wrap", rd_log[rd_base + 2049], {1'b0, 16'h0000});
      end
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
